// File: rtl/rf_writeback_if.sv
// Bundle of the result-write, issue, hazard-query and register-file write
// port signals around rf_writeback. The slave view is the writeback block;
// the master view is the surrounding pipeline and register file.
interface rf_writeback_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // ALU result source
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    // LSU result source
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    // Issue tracking and decode hazard queries
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic [ADDR_WIDTH-1:0] chk_addr1;
    logic [ADDR_WIDTH-1:0] chk_addr2;
    logic                  busy1;
    logic                  busy2;
    // Register file write port
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  idle;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  iss_valid, iss_rd, chk_addr1, chk_addr2,
        output busy1, busy2,
        output wen, waddr, wdata, idle
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output iss_valid, iss_rd, chk_addr1, chk_addr2,
        input  busy1, busy2,
        input  wen, waddr, wdata, idle
    );
endinterface

// File: rtl/rf_writeback.sv
// Register file write-side initiator: round-robin arbitration of ALU/LSU
// results onto a registered single write port, plus a per-register pending
// scoreboard that tells decode when a source register is safe to read.
module rf_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    rf_writeback_if.slave  bus
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    src_t                  last;
    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] xfer_rd;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic [NREG-1:0]       pending;
    logic [NREG-1:0]       pending_nxt;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Grant a lone valid source; on conflict grant the one not served last
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (bus.alu_valid && bus.lsu_valid) begin
            if (last == SRC_LSU) grant_alu = 1'b1;
            else                 grant_lsu = 1'b1;
        end else if (bus.alu_valid) begin
            grant_alu = 1'b1;
        end else if (bus.lsu_valid) begin
            grant_lsu = 1'b1;
        end
    end

    assign xfer      = grant_alu | grant_lsu;
    assign xfer_rd   = grant_alu ? bus.alu_rd   : bus.lsu_rd;
    assign xfer_data = grant_alu ? bus.alu_data : bus.lsu_data;

    assign bus.alu_ready = grant_alu;
    assign bus.lsu_ready = grant_lsu;

    // Remember which source won the most recent transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last <= SRC_LSU;
        else if (xfer) last <= grant_alu ? SRC_ALU : SRC_LSU;
    end

    // Output register: load on transfer, drain wen otherwise; x0 never writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= xfer && (xfer_rd != '0);
            if (xfer) begin
                waddr_q <= xfer_rd;
                wdata_q <= xfer_data;
            end
        end
    end

    // Scoreboard next state: clear first so a same-cycle issue (set) wins
    always_comb begin
        pending_nxt = pending;
        if (xfer && xfer_rd != '0)
            pending_nxt[xfer_rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != '0)
            pending_nxt[bus.iss_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    // Busy covers both outstanding and in-flight (not yet written) results
    always_comb begin
        bus.busy1 = (bus.chk_addr1 != '0) &&
                    (pending[bus.chk_addr1] || (wen_q && waddr_q == bus.chk_addr1));
        bus.busy2 = (bus.chk_addr2 != '0) &&
                    (pending[bus.chk_addr2] || (wen_q && waddr_q == bus.chk_addr2));
    end

    assign bus.wen   = wen_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.idle  = ~|pending && !wen_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback.
module tb_rf_writeback;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    rf_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
    endtask

    task automatic test_reset();
        bus.chk_addr1 = 5'd6;
        bus.chk_addr2 = 5'd6;
        #3;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %0b want 0", bus.wen); end
        tests++; if (bus.waddr !== 5'd0) begin fails++; $display("FAIL reset_waddr got %0d want 0", bus.waddr); end
        tests++; if (bus.wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata got %h want 0", bus.wdata); end
        tests++; if (bus.idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %0b want 1", bus.idle); end
        // Ready follows the arbiter even while in reset
        bus.alu_valid = 1'b1;
        #1;
        tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready got %0b want 1", bus.alu_ready); end
        bus.alu_valid = 1'b0;
        step();
        rst = 1'b0;
        // One write, then reset asynchronously mid-cycle while wen is high
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h0000_1234;
        step();
        idle_inputs();
        tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL prereset_wen got %0b want 1", bus.wen); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL async_wen got %0b want 0", bus.wen); end
        tests++; if (bus.waddr !== 5'd0) begin fails++; $display("FAIL async_waddr got %0d want 0", bus.waddr); end
        tests++; if (bus.wdata !== 32'd0) begin fails++; $display("FAIL async_wdata got %h want 0", bus.wdata); end
        tests++; if (bus.idle !== 1'b1) begin fails++; $display("FAIL async_idle got %0b want 1", bus.idle); end
        tests++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin fails++; $display("FAIL async_busy got %0b%0b want 00", bus.busy1, bus.busy2); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_alu();
        bus.chk_addr1 = 5'd5;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        step();
        bus.iss_valid = 1'b0;
        #1;
        tests++; if (bus.busy1 !== 1'b1) begin fails++; $display("FAIL alu_busy_after_issue got %0b want 1", bus.busy1); end
        tests++; if (bus.idle !== 1'b0) begin fails++; $display("FAIL alu_idle_pending got %0b want 0", bus.idle); end
        step();
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL alu_ready got %0b want 1", bus.alu_ready); end
        tests++; if (bus.lsu_ready !== 1'b0) begin fails++; $display("FAIL alu_lsu_ready got %0b want 0", bus.lsu_ready); end
        step();
        idle_inputs();
        tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL alu_wen got %0b want 1", bus.wen); end
        tests++; if (bus.waddr !== 5'd5) begin fails++; $display("FAIL alu_waddr got %0d want 5", bus.waddr); end
        tests++; if (bus.wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL alu_wdata got %h want deadbeef", bus.wdata); end
        tests++; if (bus.busy1 !== 1'b1) begin fails++; $display("FAIL alu_busy_inflight got %0b want 1", bus.busy1); end
        tests++; if (bus.idle !== 1'b0) begin fails++; $display("FAIL alu_idle_inflight got %0b want 0", bus.idle); end
        step();
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL alu_wen_drop got %0b want 0", bus.wen); end
        tests++; if (bus.busy1 !== 1'b0) begin fails++; $display("FAIL alu_busy_clear got %0b want 0", bus.busy1); end
        tests++; if (bus.idle !== 1'b1) begin fails++; $display("FAIL alu_idle_return got %0b want 1", bus.idle); end
    endtask

    task automatic test_x0();
        bus.chk_addr1 = 5'd0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        step();
        bus.iss_valid = 1'b0;
        tests++; if (bus.busy1 !== 1'b0) begin fails++; $display("FAIL x0_busy_issue got %0b want 0", bus.busy1); end
        tests++; if (bus.idle !== 1'b1) begin fails++; $display("FAIL x0_idle_issue got %0b want 1", bus.idle); end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0000_0055;
        #1;
        tests++; if (bus.lsu_ready !== 1'b1) begin fails++; $display("FAIL x0_lsu_ready got %0b want 1", bus.lsu_ready); end
        step();
        idle_inputs();
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL x0_wen got %0b want 0", bus.wen); end
        tests++; if (bus.wdata !== 32'h0000_0055) begin fails++; $display("FAIL x0_wdata got %h want 00000055", bus.wdata); end
        tests++; if (bus.busy1 !== 1'b0) begin fails++; $display("FAIL x0_busy got %0b want 0", bus.busy1); end
        step();
    endtask

    // Previous transfer was LSU, so the ALU wins the first conflict
    task automatic test_conflict();
        logic [4:0] exp_addr [4];
        logic       exp_alu  [4];
        int         ai;
        int         li;
        exp_addr = '{5'd1, 5'd9, 5'd2, 5'd10};
        exp_alu  = '{1'b1, 1'b0, 1'b1, 1'b0};
        ai = 0;
        li = 0;
        for (int k = 0; k < 4; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(1 + ai); bus.alu_data = 32'hA000_0000 + 32'(1 + ai);
            bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(9 + li); bus.lsu_data = 32'hB000_0000 + 32'(9 + li);
            #1;
            tests++; if (bus.alu_ready !== exp_alu[k] || bus.lsu_ready !== !exp_alu[k]) begin
                fails++; $display("FAIL conflict_grant%0d got alu=%0b lsu=%0b want alu=%0b", k, bus.alu_ready, bus.lsu_ready, exp_alu[k]);
            end
            step();
            if (exp_alu[k]) ai++; else li++;
            tests++; if (bus.waddr !== exp_addr[k] || bus.wen !== 1'b1) begin
                fails++; $display("FAIL conflict_waddr%0d got %0d wen=%0b want %0d wen=1", k, bus.waddr, bus.wen, exp_addr[k]);
            end
            tests++; if (bus.wdata !== ((exp_alu[k] ? 32'hA000_0000 : 32'hB000_0000) + 32'(exp_addr[k]))) begin
                fails++; $display("FAIL conflict_wdata%0d got %h want %h", k, bus.wdata, (exp_alu[k] ? 32'hA000_0000 : 32'hB000_0000) + 32'(exp_addr[k]));
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_collision();
        bus.chk_addr1 = 5'd7;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h0000_0077;
        #1;
        tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL coll_ready got %0b want 1", bus.alu_ready); end
        step();
        idle_inputs();
        tests++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd7) begin fails++; $display("FAIL coll_write got wen=%0b addr=%0d want 1/7", bus.wen, bus.waddr); end
        step();
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL coll_wen_drop got %0b want 0", bus.wen); end
        tests++; if (bus.busy1 !== 1'b1) begin fails++; $display("FAIL coll_busy_held got %0b want 1", bus.busy1); end
        tests++; if (bus.idle !== 1'b0) begin fails++; $display("FAIL coll_idle got %0b want 0", bus.idle); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h0000_0078;
        step();
        idle_inputs();
        step();
        tests++; if (bus.busy1 !== 1'b0 || bus.idle !== 1'b1) begin fails++; $display("FAIL coll_drain got busy=%0b idle=%0b want 0/1", bus.busy1, bus.idle); end
    endtask

    task automatic test_back_to_back();
        bus.chk_addr1 = 5'd3;
        bus.chk_addr2 = 5'd4;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        step();
        bus.iss_rd = 5'd4;
        step();
        bus.iss_valid = 1'b0;
        tests++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin fails++; $display("FAIL b2b_busy_issued got %0b%0b want 11", bus.busy1, bus.busy2); end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h4444_4444;
        step();
        bus.lsu_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333_3333;
        tests++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin fails++; $display("FAIL b2b_busy_n1 got %0b%0b want 11", bus.busy1, bus.busy2); end
        tests++; if (bus.waddr !== 5'd4 || bus.wdata !== 32'h4444_4444) begin fails++; $display("FAIL b2b_write4 got %0d %h want 4 44444444", bus.waddr, bus.wdata); end
        step();
        idle_inputs();
        tests++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b0) begin fails++; $display("FAIL b2b_busy_n2 got %0b%0b want 10", bus.busy1, bus.busy2); end
        tests++; if (bus.idle !== 1'b0) begin fails++; $display("FAIL b2b_idle_mid got %0b want 0", bus.idle); end
        tests++; if (bus.waddr !== 5'd3 || bus.wen !== 1'b1) begin fails++; $display("FAIL b2b_write3 got %0d wen=%0b want 3 wen=1", bus.waddr, bus.wen); end
        step();
        tests++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin fails++; $display("FAIL b2b_busy_done got %0b%0b want 00", bus.busy1, bus.busy2); end
        tests++; if (bus.idle !== 1'b1 || bus.wen !== 1'b0) begin fails++; $display("FAIL b2b_idle_done got idle=%0b wen=%0b want 1/0", bus.idle, bus.wen); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        idle_inputs();
        bus.chk_addr1 = '0;
        bus.chk_addr2 = '0;
        test_reset();
        test_single_alu();
        test_x0();
        test_conflict();
        test_collision();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
